// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, requester IDs
// and the cache-line geometry used by the read-after-write check.
package mem_arb_pkg;

  localparam int LINE_OFFSET_BITS = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IC = 2'd0,
    DC = 2'd1,
    ST = 2'd2
  } req_id_e;

  function automatic req_id_e next_req(input req_id_e id);
    case (id)
      IC:      return DC;
      DC:      return ST;
      default: return IC;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant over an eligibility mask; search starts at ptr
// and wraps IC -> DC -> ST. next_ptr is the requester after the winner.
module rr_arbiter3
  import mem_arb_pkg::*;
(
  input  logic    [2:0] eligible,
  input  req_id_e       ptr,
  output logic          grant_valid,
  output req_id_e       grant_id,
  output req_id_e       next_ptr
);

  logic [2:0] idx;

  // Walk from the farthest offset to the nearest so the closest eligible wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = IC;
    idx         = '0;
    for (int i = 2; i >= 0; i--) begin
      idx = {1'b0, ptr} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (eligible[idx[1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = req_id_e'(idx[1:0]);
      end
    end
    next_ptr = next_req(grant_id);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the data memory between icache fill,
// dcache fill and store buffer, with RAW line hazard blocking and a watchdog.
//
// state   | meaning
// IDLE    | arbitrate among eligible requesters, latch grant
// RD_WAIT | line read in flight, waiting for mem_read_done
// WR_WAIT | word write in flight, waiting for mem_write_done
// RESP    | one-cycle done pulse to the grantee
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_line,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_line,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_done,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_read_req,
  input  logic              mem_read_done,
  input  logic [LINE_W-1:0] mem_data_out,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_request,
  input  logic              mem_write_done,
  output logic              timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e          state;
  req_id_e         rr_ptr;
  req_id_e         gnt_q;
  logic [WD_W-1:0] wd_cnt;

  logic            raw_hit;
  logic [2:0]      eligible;
  logic            arb_valid;
  req_id_e         arb_id;
  req_id_e         arb_next;
  logic            wait_armed;

  assign raw_hit  = st_req && (dc_addr[ADDR_W-1:LINE_OFFSET_BITS] == st_addr[ADDR_W-1:LINE_OFFSET_BITS]);
  assign eligible = {st_req, dc_req && !raw_hit, ic_req};

  // The first wait cycle always has wd_cnt == 0, so a done left over from a
  // previous access is never taken as completion of the new one.
  assign wait_armed = (wd_cnt != '0);

  rr_arbiter3 u_rr (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .grant_valid (arb_valid),
    .grant_id    (arb_id),
    .next_ptr    (arb_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= IC;
      gnt_q             <= IC;
      wd_cnt            <= '0;
      ic_done           <= 1'b0;
      dc_done           <= 1'b0;
      st_done           <= 1'b0;
      ic_line           <= '0;
      dc_line           <= '0;
      mem_read_address  <= '0;
      mem_read_req      <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_write_request <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_q  <= arb_id;
            rr_ptr <= arb_next;
            wd_cnt <= '0;
            if (arb_id == ST) begin
              mem_write_address <= st_addr;
              mem_write_data    <= st_data;
              mem_write_request <= 1'b1;
              state             <= WR_WAIT;
            end else begin
              mem_read_address <= (arb_id == IC) ? ic_addr : dc_addr;
              mem_read_req     <= 1'b1;
              state            <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (mem_read_done && wait_armed) begin
            mem_read_req <= 1'b0;
            if (gnt_q == IC) begin
              ic_line <= mem_data_out;
              ic_done <= 1'b1;
            end else begin
              dc_line <= mem_data_out;
              dc_done <= 1'b1;
            end
            state <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err  <= 1'b1;
            mem_read_req <= 1'b0;
            wd_cnt       <= '0;
            state        <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WR_WAIT: begin
          if (mem_write_done && wait_armed) begin
            mem_write_request <= 1'b0;
            st_done           <= 1'b1;
            state             <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err       <= 1'b1;
            mem_write_request <= 1'b0;
            wd_cnt            <= '0;
            state             <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          wd_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
